spectro_frame_assembler: RTL
============================

# spectro_frame_assembler

Downstream deserializer for the spectrogram extractor. It samples the serial word stream that the PISO stage produces under the FSM's shift/load control and rebuilds 12-bit words. Each word is tagged with its slot index: 0 = RTC min/sec, 1..15 = channel counters. Tagged words are buffered in a small FIFO with a valid/ready output, so a host-side link can drain one frame per overflow event.

## Interface
Parameters:
- FIFO_DEPTH, 4: word FIFO entries, power of two, 2..16
- WORD_W, 12: bits per serial word
- N_SLOTS, 16: words per frame

Ports:
- clk  in  1  system clock, same clock as the FSM/PISO
- reset  in  1  asynchronous, active-low reset
- serial_in  in  1  PISO serial output, MSB first
- sl_in  in  1  PISO shift/load control: 1 = load cycle, 0 = shift cycle
- ovf_in  in  1  global overflow; a rising edge starts a frame
- word_data  out  12  FIFO head data
- word_idx  out  4  FIFO head slot index
- word_last  out  1  head is slot N_SLOTS-1
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts the head when word_valid=1
- busy  out  1  state ≠ IDLE
- err_short  out  1  sticky: a load arrived mid-word
- err_drop  out  1  sticky: a word completed while the FIFO was full
- frame_min  out  6  timestamp minutes (see Configuration)
- frame_sec  out  6  timestamp seconds (see Configuration)

## Operation
- ovf_in is registered once; a rise is detected as ovf_q=1 and ovf_q2=0.
- State machine:
  - IDLE: rise → ARM; slot=0; err_short and err_drop cleared.
  - ARM: waits for sl_in=1, then → SHIFT with bit_cnt=0.
  - SHIFT: each cycle with sl_in=0, shift serial_in into sreg (MSB first) and increment bit_cnt. When bit_cnt reaches WORD_W-1 and that bit is taken:
    - push {slot, word} into the FIFO;
    - if slot=N_SLOTS-1 → DONE, else slot+1 → ARM.
  - SHIFT with sl_in=1 and bit_cnt in 1..WORD_W-1: set err_short, discard the partial word, keep the slot, restart with bit_cnt=0 and stay in SHIFT.
  - SHIFT with sl_in=1 and bit_cnt=0: no action; the load is repeated.
  - DONE → IDLE after one cycle.
- A rise in any non-IDLE state aborts the current frame: partial word discarded, slot=0, → ARM. Words already in the FIFO are kept. Sticky errors are cleared.
- FIFO full at push time: word dropped, err_drop set, slot still advances.
- Push and pop in the same cycle while full: pop first, so the push succeeds.
- Reset values: all outputs 0, FIFO empty, state IDLE, slot 0, sreg 0.

## Timing
- Serial data is sampled on the rising clk edge.
- A pushed word is visible on word_valid/word_data the cycle after the edge that took its last bit, if the FIFO was empty.
- The FIFO is show-ahead; a pop happens on an edge where word_valid && word_ready.
- Minimum word period is WORD_W+1 cycles (1 load + 12 shifts). A full frame takes ≥208 cycles.
- Sticky errors assert on the edge after the offending event and hold until the next frame start or reset.
- Reset asserted mid-frame clears everything asynchronously. The first frame after release requires a fresh ovf_in rise.

## Configuration
- SPECTRO_FRAME_TS_EN defined: on the push of slot 0, word[11:6] is latched into frame_min and word[5:0] into frame_sec. They hold until the next slot-0 push or reset. A slot 0 that is dropped or aborted does not update them.
- SPECTRO_FRAME_TS_EN undefined: frame_min and frame_sec are tied to 0 and no latch registers are built.

## Structure
- Package spectro_pkg holds:
  - constants WORD_W=12, N_SLOTS=16, SLOT_RTC=0;
  - the state enum asm_state_t {IDLE, ARM, SHIFT, DONE};
  - the FIFO entry struct {idx[3:0], data[11:0]}.
- One sub-module, spectro_word_fifo: a synchronous show-ahead FIFO with full/empty flags, reset shared with the parent.

## Test plan
- Nominal frame: ovf_in rise, then 16 × (1 load + 12 shifts) sending slot k as 12'h100+k, word_ready=1. Expect 16 valid beats with idx 0..15 and data 12'h100..12'h10F; word_last only on idx 15; both errors 0; busy drops after DONE.
- Back-pressure: word_ready=0 for the whole frame with FIFO_DEPTH=4. Expect 4 entries (idx 0..3) retained, err_drop=1. Releasing ready yields exactly data 12'h100..12'h103.
- Short word: sl_in pulses after 5 bits of slot 2. Expect err_short=1; the retried slot 2 word is emitted with idx 2 and correct data; no slot skipped.
- Abort: second ovf_in rise during slot 7. Expect next emitted idx=0, errors cleared, words 0..6 from the prior frame still drained in order.
- Async reset: reset low mid-shift for one half-cycle. Expect word_valid=0, busy=0, and no output until a new ovf_in rise.
- SPECTRO_FRAME_TS_EN: slot 0 = 12'b000011_101010. Expect frame_min=3 and frame_sec=42 the cycle after the push. Without the macro, both read 0.

Source files
------------

// File: rtl/spectro_pkg.sv
// Shared types and constants for the spectrogram frame assembler.
// Optional timestamp latching is enabled by defining SPECTRO_FRAME_TS_EN.
package spectro_pkg;

  localparam int WORD_W   = 12;
  localparam int N_SLOTS  = 16;
  localparam int SLOT_RTC = 0;

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, DONE} asm_state_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [11:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/spectro_word_fifo.sv
// Synchronous show-ahead FIFO of tagged words; a simultaneous pop frees room
// for a push issued while full.
module spectro_word_fifo
  import spectro_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        empty,
  output logic        accepted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign accepted = push && (!full || do_pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({accepted, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spectro_frame_assembler.sv
// Rebuilds tagged 12-bit words from the PISO serial stream into a word FIFO.
// Define SPECTRO_FRAME_TS_EN to latch the slot-0 RTC word into frame_min/frame_sec.
module spectro_frame_assembler #(
  parameter int FIFO_DEPTH = 4,
  parameter int WORD_W     = 12,
  parameter int N_SLOTS    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              sl_in,
  input  logic              ovf_in,
  output logic [WORD_W-1:0] word_data,
  output logic [3:0]        word_idx,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              err_short,
  output logic              err_drop,
  output logic [5:0]        frame_min,
  output logic [5:0]        frame_sec
);
  import spectro_pkg::*;

  localparam int CW = $clog2(WORD_W);

  asm_state_t        state;
  logic [3:0]        slot;
  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-2:0] sreg;
  logic              ovf_q;
  logic              ovf_q2;
  logic              rise;
  logic              push;
  logic              accepted;
  logic              empty;
  fifo_entry_t       push_data;
  fifo_entry_t       head;

  assign rise = ovf_q && !ovf_q2;
  // An overflow rise wins over a final bit taken on the same edge.
  assign push = (state == SHIFT) && !sl_in && (bit_cnt == CW'(WORD_W-1)) && !rise;
  assign push_data.idx  = slot;
  assign push_data.data = {sreg, serial_in};

  spectro_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (word_ready),
    .head     (head),
    .empty    (empty),
    .accepted (accepted)
  );

  assign word_valid = !empty;
  assign word_data  = word_valid ? head.data : '0;
  assign word_idx   = word_valid ? head.idx  : '0;
  assign word_last  = word_valid && (head.idx == 4'(N_SLOTS-1));
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      slot      <= '0;
      bit_cnt   <= '0;
      sreg      <= '0;
      ovf_q     <= 1'b0;
      ovf_q2    <= 1'b0;
      err_short <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      ovf_q  <= ovf_in;
      ovf_q2 <= ovf_q;
      if (rise) begin
        state     <= ARM;
        slot      <= '0;
        bit_cnt   <= '0;
        err_short <= 1'b0;
        err_drop  <= 1'b0;
      end else begin
        if (push && !accepted) err_drop <= 1'b1;
        case (state)
          IDLE: ;
          ARM: begin
            if (sl_in) begin
              state   <= SHIFT;
              bit_cnt <= '0;
            end
          end
          SHIFT: begin
            if (sl_in) begin
              if (bit_cnt != '0) err_short <= 1'b1;
              bit_cnt <= '0;
            end else begin
              sreg <= {sreg[WORD_W-3:0], serial_in};
              if (push) begin
                bit_cnt <= '0;
                if (slot == 4'(N_SLOTS-1)) begin
                  state <= DONE;
                end else begin
                  slot  <= slot + 4'd1;
                  state <= ARM;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPECTRO_FRAME_TS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_min <= '0;
      frame_sec <= '0;
    end else if (accepted && (push_data.idx == 4'(SLOT_RTC))) begin
      frame_min <= push_data.data[11:6];
      frame_sec <= push_data.data[5:0];
    end
  end
`else
  assign frame_min = '0;
  assign frame_sec = '0;
`endif

endmodule
